// File: rtl/aw_flush_ctrl.sv
// Write-address gate that flushes the read prefetcher before forwarding any AW hitting its window.
// Optional flush statistics counter is enabled with the AW_FLUSH_STATS_EN macro.
module aw_flush_ctrl #(
  parameter int ADDR_BITS     = 16,
  parameter int TID_WIDTH     = 8,
  parameter int WATCHDOG_SIZE = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_aw_valid,
  output logic                     s_aw_ready,
  input  logic [ADDR_BITS-1:0]     s_aw_addr,
  input  logic [TID_WIDTH-1:0]     s_aw_id,
  output logic                     m_aw_valid,
  input  logic                     m_aw_ready,
  output logic [ADDR_BITS-1:0]     m_aw_addr,
  output logic [TID_WIDTH-1:0]     m_aw_id,
  input  logic [ADDR_BITS-1:0]     bar,
  input  logic [ADDR_BITS-1:0]     limit,
  output logic                     flush_req,
  input  logic                     flush_ack,
  input  logic                     pf_busy,
  input  logic [WATCHDOG_SIZE-1:0] watchdogCnt,
  output logic                     err_timeout,
  output logic [7:0]               flush_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH_REQ,
    ST_FLUSH_WAIT,
    ST_FORWARD
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [TID_WIDTH-1:0]     id_q, id_d;
  logic [WATCHDOG_SIZE-1:0] wd_q, wd_d;
  logic                     err_q, err_d;
  logic [WATCHDOG_SIZE-1:0] wdNext;
  logic                     wdExpired;
  logic                     hit;

  // An inverted window (bar > limit) can never satisfy both bounds, so it never hits.
  assign hit       = (bar <= s_aw_addr) && (s_aw_addr <= limit);
  assign wdNext    = wd_q + {{(WATCHDOG_SIZE-1){1'b0}}, 1'b1};
  assign wdExpired = (watchdogCnt != '0) && (wdNext == watchdogCnt);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (s_aw_valid) begin
          addr_d  = s_aw_addr;
          id_d    = s_aw_id;
          wd_d    = '0;
          state_d = hit ? ST_FLUSH_REQ : ST_FORWARD;
        end
      end
      // A real handshake in the same cycle as expiry wins over the timeout.
      ST_FLUSH_REQ: begin
        wd_d = wdNext;
        if (flush_ack) begin
          state_d = ST_FLUSH_WAIT;
        end else if (wdExpired) begin
          err_d   = 1'b1;
          state_d = ST_FORWARD;
        end
      end
      ST_FLUSH_WAIT: begin
        wd_d = wdNext;
        if (!pf_busy) begin
          state_d = ST_FORWARD;
        end else if (wdExpired) begin
          err_d   = 1'b1;
          state_d = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        if (m_aw_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign s_aw_ready  = (state_q == ST_IDLE);
  assign flush_req   = (state_q == ST_FLUSH_REQ);
  assign m_aw_valid  = (state_q == ST_FORWARD);
  assign m_aw_addr   = addr_q;
  assign m_aw_id     = id_q;
  assign err_timeout = err_q;

`ifdef AW_FLUSH_STATS_EN
  logic [7:0] flushCnt_q;
  logic       flushDone;

  // Only a prefetcher that drained counts as a completed flush; timeouts do not.
  assign flushDone = (state_q == ST_FLUSH_WAIT) && !pf_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      flushCnt_q <= 8'd0;
    end else if (flushDone && (flushCnt_q != 8'hFF)) begin
      flushCnt_q <= flushCnt_q + 8'd1;
    end
  end

  assign flush_cnt = flushCnt_q;
`else
  assign flush_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_aw_flush_ctrl.sv
// Self-checking bench for aw_flush_ctrl: vector table of AW transactions plus hand-written
// timeout, reset and saturation sequences, with a scoreboard queue for forwarded AWs.
module tb_aw_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_aw_valid = 1'b0;
  logic        s_aw_ready;
  logic [15:0] s_aw_addr = '0;
  logic [7:0]  s_aw_id = '0;
  logic        m_aw_valid;
  logic        m_aw_ready = 1'b0;
  logic [15:0] m_aw_addr;
  logic [7:0]  m_aw_id;
  logic [15:0] bar = '0;
  logic [15:0] limit = '0;
  logic        flush_req;
  logic        flush_ack = 1'b0;
  logic        pf_busy = 1'b0;
  logic [9:0]  watchdogCnt = '0;
  logic        err_timeout;
  logic [7:0]  flush_cnt;

  aw_flush_ctrl #(.ADDR_BITS(16), .TID_WIDTH(8), .WATCHDOG_SIZE(10)) dut (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .bar(bar), .limit(limit), .flush_req(flush_req), .flush_ack(flush_ack), .pf_busy(pf_busy),
    .watchdogCnt(watchdogCnt), .err_timeout(err_timeout), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bar;
    logic [15:0] limit;
    logic [15:0] addr;
    logic [7:0]  id;
    bit          hit;
    int          ackDelay;
    int          busyCycles;
    int          readyDelay;
    logic [9:0]  wd;
  } vec_t;

  vec_t        vecs[9];
  logic [23:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          expFlushCnt = 0;
  bit          expErr = 1'b0;

  function automatic int expCnt();
`ifdef AW_FLUSH_STATS_EN
    return expFlushCnt;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkForwarded();
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_nonempty", 32'(0), 32'(1));
    end else begin
      checkOutput("m_aw_addr", 32'(m_aw_addr), 32'(expQ[0][23:8]));
      checkOutput("m_aw_id", 32'(m_aw_id), 32'(expQ[0][7:0]));
    end
  endtask

  // Cycle c counts negedges after the accepting edge; all stimulus and sampling is on negedges.
  task automatic applyStimulus(input vec_t v);
    int  fwd;
    bit  done;
    @(negedge clk);
    bar = v.bar; limit = v.limit; watchdogCnt = v.wd;
    s_aw_valid = 1'b1; s_aw_addr = v.addr; s_aw_id = v.id;
    flush_ack = 1'b0; pf_busy = 1'b0; m_aw_ready = 1'b0;
    checkOutput("s_aw_ready_idle", 32'(s_aw_ready), 32'(1));
    expQ.push_back({v.addr, v.id});
    fwd  = v.hit ? v.ackDelay + v.busyCycles + 2 : 1;
    done = 1'b0;
    for (int c = 1; c < 200 && !done; c++) begin
      @(negedge clk);
      s_aw_valid = 1'b0; s_aw_addr = 16'($urandom); s_aw_id = 8'($urandom);
      flush_ack  = v.hit && (c == v.ackDelay);
      pf_busy    = v.hit && (c <= v.ackDelay + v.busyCycles);
      m_aw_ready = (c >= fwd + v.readyDelay);
      checkOutput("s_aw_ready_busy", 32'(s_aw_ready), 32'(0));
      checkOutput("flush_req", 32'(flush_req), 32'(v.hit && (c <= v.ackDelay)));
      checkOutput("m_aw_valid", 32'(m_aw_valid), 32'(c >= fwd));
      checkOutput("err_timeout", 32'(err_timeout), 32'(expErr));
      if (m_aw_valid) begin
        checkForwarded();
        if (m_aw_ready) begin
          if (expQ.size() != 0) void'(expQ.pop_front());
          done = 1'b1;
        end
      end
    end
    if (!done) checkOutput("forward_within_budget", 32'(0), 32'(1));
    if (v.hit) expFlushCnt = (expFlushCnt == 255) ? 255 : expFlushCnt + 1;
    @(negedge clk);
    m_aw_ready = 1'b0; flush_ack = 1'b0; pf_busy = 1'b0;
    checkOutput("s_aw_ready_after", 32'(s_aw_ready), 32'(1));
    checkOutput("m_aw_valid_after", 32'(m_aw_valid), 32'(0));
    checkOutput("flush_cnt", 32'(flush_cnt), 32'(expCnt()));
  endtask

  task automatic checkResetState();
    checkOutput("rst_s_aw_ready", 32'(s_aw_ready), 32'(1));
    checkOutput("rst_m_aw_valid", 32'(m_aw_valid), 32'(0));
    checkOutput("rst_flush_req", 32'(flush_req), 32'(0));
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'(0));
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'(0));
    checkOutput("rst_m_aw_addr", 32'(m_aw_addr), 32'(0));
    checkOutput("rst_m_aw_id", 32'(m_aw_id), 32'(0));
  endtask

  initial begin
    //         bar       limit     addr      id    hit  ack busy rdy wd
    vecs[0] = '{16'h0000, 16'h1DDE, 16'h2000, 8'd5, 0,   0,  0,   0,  10'd0};
    vecs[1] = '{16'h0000, 16'h1DDE, 16'h0EEF, 8'd3, 1,   3,  2,   0,  10'd0};
    vecs[2] = '{16'h0000, 16'h1DDE, 16'h3000, 8'd7, 0,   0,  0,   5,  10'd0};
    vecs[3] = '{16'h0100, 16'h00FF, 16'h0100, 8'd1, 0,   0,  0,   0,  10'd0};
    vecs[4] = '{16'h0100, 16'h0200, 16'h0100, 8'd2, 1,   1,  0,   1,  10'd0};
    vecs[5] = '{16'h0100, 16'h0200, 16'h0200, 8'd4, 1,   2,  1,   0,  10'd20};
    vecs[6] = '{16'h0100, 16'h0200, 16'h0201, 8'd6, 0,   0,  0,   2,  10'd0};
    vecs[7] = '{16'h0100, 16'h0200, 16'h00FF, 8'd8, 0,   0,  0,   0,  10'd0};
    vecs[8] = '{16'hF000, 16'hFFFF, 16'hFFFF, 8'hAB, 1,  4,  3,   2,  10'd12};

    @(negedge clk);
    checkResetState();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Hit whose flush is never acknowledged must time out after 10 cycles and still forward.
    @(negedge clk);
    bar = 16'h0000; limit = 16'h1DDE; watchdogCnt = 10'd10;
    s_aw_valid = 1'b1; s_aw_addr = 16'h0100; s_aw_id = 8'd9;
    checkOutput("to_s_aw_ready", 32'(s_aw_ready), 32'(1));
    expQ.push_back({16'h0100, 8'd9});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      s_aw_valid = 1'b0; flush_ack = 1'b0; pf_busy = 1'b1;
      checkOutput("to_flush_req_held", 32'(flush_req), 32'(1));
      checkOutput("to_err_low", 32'(err_timeout), 32'(0));
      checkOutput("to_m_aw_valid_low", 32'(m_aw_valid), 32'(0));
    end
    @(negedge clk);
    checkOutput("to_flush_req_drop", 32'(flush_req), 32'(0));
    checkOutput("to_err_set", 32'(err_timeout), 32'(1));
    checkOutput("to_m_aw_valid", 32'(m_aw_valid), 32'(1));
    checkForwarded();
    if (expQ.size() != 0) void'(expQ.pop_front());
    m_aw_ready = 1'b1; pf_busy = 1'b0;
    @(negedge clk);
    m_aw_ready = 1'b0; watchdogCnt = 10'd0;
    expErr = 1'b1;
    checkOutput("to_idle", 32'(s_aw_ready), 32'(1));
    checkOutput("to_err_sticky", 32'(err_timeout), 32'(1));
    checkOutput("to_flush_cnt", 32'(flush_cnt), 32'(expCnt()));
    applyStimulus(vecs[0]);

    // Reset while waiting for the prefetcher to drain.
    @(negedge clk);
    bar = 16'h0000; limit = 16'h1DDE;
    s_aw_valid = 1'b1; s_aw_addr = 16'h0EEF; s_aw_id = 8'd3;
    @(negedge clk);
    s_aw_valid = 1'b0; flush_ack = 1'b1; pf_busy = 1'b1;
    checkOutput("rw_flush_req", 32'(flush_req), 32'(1));
    @(negedge clk);
    flush_ack = 1'b0;
    checkOutput("rw_in_wait", 32'(flush_req), 32'(0));
    checkOutput("rw_no_valid", 32'(m_aw_valid), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pf_busy = 1'b0; m_aw_ready = 1'b1;
    expQ.delete(); expFlushCnt = 0; expErr = 1'b0;
    checkResetState();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("rw_no_valid_after", 32'(m_aw_valid), 32'(0));
    end
    m_aw_ready = 1'b0;

    // Reset while an AW is stalled on the DRAM side.
    @(negedge clk);
    s_aw_valid = 1'b1; s_aw_addr = 16'h3000; s_aw_id = 8'd7;
    @(negedge clk);
    s_aw_valid = 1'b0;
    checkOutput("rf_valid", 32'(m_aw_valid), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("rf_no_valid_after", 32'(m_aw_valid), 32'(0));
    end

    for (int n = 0; n < 256; n++) applyStimulus(vecs[4]);
    checkOutput("flush_cnt_saturated", 32'(flush_cnt), 32'(expCnt()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
